// File: rtl/commit_progress_monitor.sv
// Commit-progress monitor: counts retired instructions beside the ROB commit port,
// runs a programmable stall watchdog and emits periodic snapshot reports until halt.
module commit_progress_monitor #(
    parameter int COMMIT_WIDTH    = 6,
    parameter int CNT_W           = 64,
    parameter int TIMER_W         = 32,
    parameter int REPORT_INTERVAL = 10000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [COMMIT_WIDTH-1:0] commit_valid,
    input  logic                    commit_is_walk,
    input  logic [TIMER_W-1:0]      stuck_threshold,
    input  logic                    halt,
    input  logic                    stuck_clear,
    output logic [CNT_W-1:0]        instr_count,
    output logic [CNT_W-1:0]        cycle_count,
    output logic                    stuck,
    output logic                    done,
    output logic [1:0]              state,
    output logic                    report_valid,
    output logic [CNT_W-1:0]        report_cycle,
    output logic [CNT_W-1:0]        report_instr,
    output logic [CNT_W-1:0]        report_delta
);

    localparam int N_W  = $clog2(COMMIT_WIDTH + 1);
    localparam int IC_W = (REPORT_INTERVAL > 1) ? $clog2(REPORT_INTERVAL) : 1;
    localparam logic [IC_W-1:0] IC_LAST = IC_W'(REPORT_INTERVAL - 1);

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        RUN    = 2'd1,
        STUCK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t cur_state;
    state_t next_state;

    logic [N_W-1:0]     commit_n;
    logic               has_commit;
    logic [TIMER_W-1:0] stuck_timer;
    logic [IC_W-1:0]    interval_cnt;
    logic               threshold_hit;

    logic               active;
    logic               timer_clear;
    logic               timer_inc;
    logic               stuck_next;
    logic               report_fire;
    logic [CNT_W-1:0]   cycle_next;
    logic [CNT_W-1:0]   instr_next;
    logic [CNT_W:0]     instr_sum;

    // Walk cycles replay already-retired instructions, so every lane is ignored.
    always_comb begin
        commit_n = '0;
        if (!commit_is_walk) begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                commit_n = commit_n + N_W'(commit_valid[i]);
            end
        end
    end

    assign has_commit = (commit_n != '0);

    // Compared one bit wider so an all-ones timer cannot wrap past the threshold.
    assign threshold_hit = (stuck_threshold != '0) && !has_commit &&
                           (({1'b0, stuck_timer} + (TIMER_W + 1)'(1)) >= {1'b0, stuck_threshold});

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state <= WARMUP;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            WARMUP: begin
                if (halt) begin
                    next_state = DONE;
                end else if (has_commit) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (halt) begin
                    next_state = DONE;
                end else if (threshold_hit) begin
                    next_state = STUCK;
                end
            end
            STUCK: begin
                if (halt) begin
                    next_state = DONE;
                end else if (stuck_clear) begin
                    next_state = RUN;
                end
            end
            default: next_state = DONE;
        endcase
    end

    always_comb begin
        active      = (cur_state != DONE);
        timer_clear = (cur_state == WARMUP) || has_commit || stuck_clear;
        timer_inc   = (cur_state == RUN);
        report_fire = active && (interval_cnt == IC_LAST);
        stuck_next  = stuck;
        case (cur_state)
            RUN: begin
                if (next_state == STUCK) begin
                    stuck_next = 1'b1;
                end
            end
            STUCK: begin
                if (next_state == RUN) begin
                    stuck_next = 1'b0;
                end
            end
            default: stuck_next = stuck;
        endcase
    end

    assign cycle_next = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
    assign instr_sum  = {1'b0, instr_count} + (CNT_W + 1)'(commit_n);
    assign instr_next = instr_sum[CNT_W] ? '1 : instr_sum[CNT_W-1:0];

    // The previous report_instr doubles as the baseline for the next delta.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count  <= '0;
            instr_count  <= '0;
            stuck_timer  <= '0;
            interval_cnt <= '0;
            stuck        <= 1'b0;
            done         <= 1'b0;
            report_valid <= 1'b0;
            report_cycle <= '0;
            report_instr <= '0;
            report_delta <= '0;
        end else begin
            stuck        <= stuck_next;
            done         <= (next_state == DONE);
            report_valid <= report_fire;
            if (active) begin
                cycle_count <= cycle_next;
                instr_count <= instr_next;
                if (timer_clear) begin
                    stuck_timer <= '0;
                end else if (timer_inc && (stuck_timer != '1)) begin
                    stuck_timer <= stuck_timer + TIMER_W'(1);
                end
                if (report_fire) begin
                    interval_cnt <= '0;
                    report_cycle <= cycle_next;
                    report_instr <= instr_next;
                    report_delta <= instr_next - report_instr;
                end else begin
                    interval_cnt <= interval_cnt + IC_W'(1);
                end
            end
        end
    end

    assign state = cur_state;

endmodule
